reg_file_rd_streamer: RTL and testbench

- Reader-side sequencer for the 1-write/2-read hypervector register file.
- On a start command it walks a contiguous, wrap-around range of register addresses through one combinational read port.
- It captures each word into an output register and drains it over a valid/ready stream to downstream HDC units (encoder, similarity, memory writeback).
- It frees upstream control from per-cycle address generation and tolerates downstream back-pressure.

---
 rtl/reg_file_rd_streamer_pkg.sv | 9 +
 rtl/reg_file_rd_streamer.sv | 104 ++++++++++
 tb/tb_reg_file_rd_streamer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_rd_streamer_pkg.sv
// Shared sequencer definitions for the hypervector register-file access blocks.
package reg_file_rd_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1
  } streamer_state_e;

endpackage

// File: rtl/reg_file_rd_streamer.sv
// Reader-side burst sequencer: walks a wrap-around register range through one
// combinational read port and drains the captured words over valid/ready.
module reg_file_rd_streamer
  import reg_file_rd_streamer_pkg::*;
#(
  parameter int unsigned DataWidth    = 512,
  parameter int unsigned NumRegs      = 4,
  parameter int unsigned CountWidth   = 8,
  parameter int unsigned NumRegsWidth = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [NumRegsWidth-1:0] base_addr_i,
  input  logic [CountWidth-1:0]   num_reads_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [NumRegsWidth-1:0] rf_rd_addr_o,
  input  logic [DataWidth-1:0]    rf_rd_data_i,
  output logic [DataWidth-1:0]    data_o,
  output logic                    data_valid_o,
  input  logic                    data_ready_i
);

  // Modulo-NumRegs step; explicit compare so non-power-of-two sizes wrap too.
  function automatic logic [NumRegsWidth-1:0] f_next_ptr(
    input logic [NumRegsWidth-1:0] ptr
  );
    if (ptr == NumRegsWidth'(NumRegs - 1)) begin
      return '0;
    end
    return ptr + NumRegsWidth'(1);
  endfunction

  streamer_state_e         r_state;
  logic [CountWidth-1:0]   r_remaining;
  logic [NumRegsWidth-1:0] r_ptr;
  logic [DataWidth-1:0]    r_data;
  logic                    r_valid;
  logic                    r_done;

  logic w_stream;
  logic w_load;
  logic w_xfer;

  assign w_stream = (r_state == STREAM);
  assign w_xfer   = r_valid && data_ready_i;
  assign w_load   = w_stream && (r_remaining != '0) && (!r_valid || data_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_ptr       <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort_i) begin
        // Cancel wins over everything; pointer and last word are left as-is.
        r_state     <= IDLE;
        r_valid     <= 1'b0;
        r_remaining <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start_i) begin
              if (num_reads_i != '0) begin
                r_state     <= STREAM;
                r_ptr       <= base_addr_i;
                r_remaining <= num_reads_i;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          STREAM: begin
            if (w_load) begin
              r_data      <= rf_rd_data_i;
              r_valid     <= 1'b1;
              r_ptr       <= f_next_ptr(r_ptr);
              r_remaining <= r_remaining - CountWidth'(1);
            end else if (w_xfer) begin
              // Last word handed off with nothing left to load: burst complete.
              r_valid <= 1'b0;
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o       = w_stream;
  assign done_o       = r_done;
  assign rf_rd_addr_o = r_ptr;
  assign data_o       = r_data;
  assign data_valid_o = r_valid;

endmodule

// File: tb/tb_reg_file_rd_streamer.sv
// Bench for reg_file_rd_streamer: queue-based burst model checked every cycle,
// directed scenarios pinned by literal expectations, then randomized traffic.
module tb_reg_file_rd_streamer;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int CW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          data_ready_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [CW-1:0] num_reads_i = '0;
  logic          busy_o, done_o, data_valid_o;
  logic [AW-1:0] rf_rd_addr_o;
  logic [DW-1:0] rf_rd_data_i, data_o;

  logic [DW-1:0] regs [NR];
  assign rf_rd_data_i = regs[rf_rd_addr_o];

  reg_file_rd_streamer #(
    .DataWidth (DW),
    .NumRegs   (NR),
    .CountWidth(CW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_reads_i (num_reads_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rf_rd_addr_o(rf_rd_addr_o),
    .rf_rd_data_i(rf_rd_data_i),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Burst model: pending words, cycles since acceptance, words handed off.
  bit            m_busy = 0;
  bit            m_done = 0;
  int            m_age = 0;
  int            m_base = 0;
  int            m_xfers = 0;
  int            m_total = 0;
  bit            m_ev = 0;
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] got_q [$];
  int            addr_log [$];
  logic [DW-1:0] eq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_q(input string nm, input logic [DW-1:0] act[$], input logic [DW-1:0] exp[$]);
    chk({nm, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++) chk(nm, act[i], exp[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int b, input int n);
    start_i     = 1'b1;
    base_addr_i = AW'(b);
    num_reads_i = CW'(n);
    tick();
    start_i     = 1'b0;
    base_addr_i = AW'($urandom);
    num_reads_i = CW'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy_o && k < budget) begin
      tick();
      k++;
    end
    chk("idle_timeout", busy_o, 0);
  endtask

  // Compare process: outputs are checked at every falling edge, then the
  // model advances using the inputs that the next rising edge will see.
  initial forever begin
    @(negedge clk);
    if (!rst_ni) begin
      m_busy = 0; m_done = 0; m_age = 0; m_xfers = 0; m_total = 0; m_base = 0;
      m_q.delete();
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_valid", data_valid_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_addr", rf_rd_addr_o, 0);
    end else begin
      m_ev = m_busy && (m_age >= 1);
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done);
      chk("valid", data_valid_o, m_ev);
      if (m_ev && m_q.size() > 0) chk("data", data_o, m_q[0]);
      if (m_busy) chk("rd_addr", rf_rd_addr_o, (m_base + m_xfers + (m_ev ? 1 : 0)) % NR);
      if (!abort_i && m_busy && (m_xfers + (m_ev ? 1 : 0)) < m_total && (!m_ev || data_ready_i))
        addr_log.push_back(int'(rf_rd_addr_o));
      if (abort_i) begin
        m_busy = 0;
        m_done = 0;
        m_q.delete();
      end else if (m_busy) begin
        m_done = 0;
        if (m_ev && data_ready_i) begin
          got_q.push_back(data_o);
          void'(m_q.pop_front());
          m_xfers++;
          if (m_q.size() == 0) begin
            m_busy = 0;
            m_done = 1;
          end
        end
        m_age++;
      end else begin
        m_done = start_i && (num_reads_i == 0);
        if (start_i && num_reads_i != 0) begin
          m_busy  = 1;
          m_age   = 0;
          m_xfers = 0;
          m_base  = int'(base_addr_i);
          m_total = int'(num_reads_i);
          m_q.delete();
          for (int i = 0; i < m_total; i++) m_q.push_back(regs[(m_base + i) % NR]);
        end
      end
    end
  end

  initial begin
    int  k;
    int  idx;
    bit  wrote;
    bit  pat [3];
    int  exp_addr [6];
    regs = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    pat = '{1'b1, 1'b0, 1'b0};
    exp_addr = '{3, 0, 1, 2, 3, 0};
    data_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    tick();

    // Basic burst with first-valid latency
    got_q.delete();
    start_burst(1, 3);
    @(negedge clk); #1;
    chk("t1_valid", data_valid_o, 0);
    chk("t1_busy", busy_o, 1);
    @(negedge clk); #1;
    chk("t2_valid", data_valid_o, 1);
    chk("t2_data", data_o, 8'hA1);
    tick();
    wait_idle(50);
    chk("basic_done", done_o, 1);
    eq = '{8'hA1, 8'hA2, 8'hA3};
    chk_q("basic", got_q, eq);

    // Wrap and re-read, started in the done cycle of the previous burst
    got_q.delete();
    addr_log.delete();
    start_burst(3, 6);
    wait_idle(50);
    chk("wrap_done", done_o, 1);
    eq = '{8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    chk_q("wrap", got_q, eq);
    chk("wrap_addr_len", addr_log.size(), 6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++) chk("wrap_addr", addr_log[i], exp_addr[i]);

    // Back-pressure, with a register overwrite while 0xA1 is held
    tick();
    got_q.delete();
    wrote = 0;
    start_burst(0, 4);
    idx = 0;
    k = 0;
    while (busy_o && k < 100) begin
      data_ready_i = pat[idx % 3];
      idx++;
      if (data_valid_o && data_o == 8'hA1 && !data_ready_i) begin
        regs[1] = 8'hFF;
        wrote = 1;
      end
      tick();
      k++;
    end
    chk("bp_timeout", busy_o, 0);
    chk("bp_held_write", wrote, 1);
    eq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    chk_q("bp", got_q, eq);
    regs[1] = 8'hA1;
    data_ready_i = 1'b1;

    // Zero-length burst
    tick();
    start_burst(2, 0);
    chk("zero_done", done_o, 1);
    chk("zero_busy", busy_o, 0);
    chk("zero_valid", data_valid_o, 0);
    tick();
    chk("zero_done_clr", done_o, 0);

    // Start while busy is ignored
    got_q.delete();
    start_burst(2, 3);
    start_i = 1'b1; base_addr_i = 2'd0; num_reads_i = 8'd5;
    tick();
    start_i = 1'b0;
    wait_idle(50);
    eq = '{8'hA2, 8'hA3, 8'hA0};
    chk_q("busy_start", got_q, eq);

    // Abort after two transfers
    tick();
    got_q.delete();
    start_burst(0, 4);
    k = 0;
    while (got_q.size() < 2 && k < 50) begin
      tick();
      k++;
    end
    chk("abort_reach", got_q.size(), 2);
    abort_i = 1'b1;
    data_ready_i = 1'b0;
    tick();
    abort_i = 1'b0;
    data_ready_i = 1'b1;
    chk("abort_valid", data_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    tick();
    chk("abort_no_done", done_o, 0);
    got_q.delete();
    start_burst(2, 2);
    wait_idle(50);
    eq = '{8'hA2, 8'hA3};
    chk_q("post_abort", got_q, eq);

    // Asynchronous reset with a word held
    tick();
    data_ready_i = 1'b0;
    start_burst(0, 4);
    tick();
    tick();
    chk("pre_rst_valid", data_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", data_valid_o, 0);
    chk("arst_data", data_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_addr", rf_rd_addr_o, 0);
    @(posedge clk); #1 rst_ni = 1'b1;
    data_ready_i = 1'b1;
    tick();
    got_q.delete();
    start_burst(1, 2);
    wait_idle(50);
    chk("post_rst_done", done_o, 1);
    eq = '{8'hA1, 8'hA2};
    chk_q("post_rst", got_q, eq);

    // Randomized traffic against the model
    for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
    got_q.delete();
    repeat (3000) begin
      start_i      = ($urandom_range(0, 5) == 0);
      base_addr_i  = AW'($urandom);
      num_reads_i  = CW'($urandom_range(0, 9));
      abort_i      = ($urandom_range(0, 60) == 0);
      data_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    data_ready_i = 1'b1;
    wait_idle(100);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
